booth_signed_multiplier_seq: RTL and testbench

- Sequential radix-2 Booth multiplier for 16-bit two's-complement operands, producing a 32-bit signed product. It is the inverse-operation companion to the signed restoring divider in the same arithmetic unit.
- Uses one add/subtract plus arithmetic shift per clock, behind a start/busy/done handshake.
- Status flags are ZE, NE and OVF, mirroring the divider's flag style, so the unit's ALU wrapper can mux either block's results.

---
 rtl/booth_signed_multiplier_seq.sv | 118 +++++++++++
 tb/tb_booth_signed_multiplier_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/booth_signed_multiplier_seq.sv
// Sequential radix-2 Booth multiplier: signed WIDTH x WIDTH -> 2*WIDTH product,
// one add/subtract plus arithmetic shift per clock behind a start/busy/done handshake.
module booth_signed_multiplier_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    output logic [2*WIDTH-1:0]   Prod,
    output logic                 busy,
    output logic                 done,
    output logic                 ZE,
    output logic                 NE,
    output logic                 OVF
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, next_state;

    // One guard bit above WIDTH keeps A - Mr from wrapping when M is the most negative value.
    logic [WIDTH:0]       acc;
    logic [WIDTH:0]       mr;
    logic [WIDTH-1:0]     qr;
    logic                 q1;
    logic [CNT_W-1:0]     cnt;

    logic [WIDTH:0]       acc_op;
    logic [WIDTH:0]       acc_sh;
    logic [WIDTH-1:0]     qr_sh;
    logic [2*WIDTH-1:0]   prod_next;
    logic                 last_step;

    always_comb begin
        acc_op = acc;
        case ({qr[0], q1})
            2'b01:   acc_op = acc + mr;
            2'b10:   acc_op = acc - mr;
            default: acc_op = acc;
        endcase
        acc_sh    = {acc_op[WIDTH], acc_op[WIDTH:1]};
        qr_sh     = {acc_op[0], qr[WIDTH-1:1]};
        prod_next = {acc_sh[WIDTH-1:0], qr_sh};
    end

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Results and flags only change on the final step, so they hold across later operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            mr   <= '0;
            qr   <= '0;
            q1   <= 1'b0;
            cnt  <= '0;
            Prod <= '0;
            ZE   <= 1'b0;
            NE   <= 1'b0;
            OVF  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        mr  <= {M[WIDTH-1], M};
                        qr  <= Q;
                        q1  <= 1'b0;
                        cnt <= '0;
                    end
                end
                RUN: begin
                    acc <= acc_sh;
                    qr  <= qr_sh;
                    q1  <= qr[0];
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        Prod <= prod_next;
                        ZE   <= (prod_next == '0);
                        NE   <= prod_next[2*WIDTH-1];
                        OVF  <= !((&prod_next[2*WIDTH-1:WIDTH-1]) ||
                                  !(|prod_next[2*WIDTH-1:WIDTH-1]));
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_booth_signed_multiplier_seq.sv
// Self-checking bench for booth_signed_multiplier_seq: directed corners plus random operands
// compared against plain signed multiplication.
module tb_booth_signed_multiplier_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] M;
    logic [15:0] Q;
    logic [31:0] Prod;
    logic        busy;
    logic        done;
    logic        ZE;
    logic        NE;
    logic        OVF;

    int          checks;
    int          errors;
    logic [31:0] prevProd;

    booth_signed_multiplier_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .M     (M),
        .Q     (Q),
        .Prod  (Prod),
        .busy  (busy),
        .done  (done),
        .ZE    (ZE),
        .NE    (NE),
        .OVF   (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] refProd(input logic [15:0] m, input logic [15:0] q);
        longint p;
        p = longint'($signed(m)) * longint'($signed(q));
        return p[31:0];
    endfunction

    // Flags derived from the true integer product rather than from bit patterns.
    task automatic checkOutput(input string tag, input logic [15:0] m, input logic [15:0] q);
        longint p;
        logic [31:0] exp32;
        p = longint'($signed(m)) * longint'($signed(q));
        exp32 = refProd(m, q);
        checkValue({tag, "_prod"}, {32'b0, Prod}, {32'b0, exp32});
        checkValue({tag, "_ze"},   {63'b0, ZE},   {63'b0, (p == 0)});
        checkValue({tag, "_ne"},   {63'b0, NE},   {63'b0, (p < 0)});
        checkValue({tag, "_ovf"},  {63'b0, OVF},  {63'b0, (p > 32767 || p < -32768)});
    endtask

    // Called just after a negedge with the DUT idle; returns one negedge after the capture edge.
    task automatic applyStimulus(input logic [15:0] m, input logic [15:0] q);
        M = m;
        Q = q;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [15:0] m, input logic [15:0] q, input int pokeAt);
        int lat;
        int busyCnt;
        applyStimulus(m, q);
        lat = 1;
        busyCnt = 0;
        checkValue({tag, "_hold"}, {32'b0, Prod}, {32'b0, prevProd});
        while (!done && lat < 40) begin
            busyCnt += busy;
            if (lat == pokeAt) begin
                start = 1'b1;
                M = 16'($urandom);
                Q = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        checkValue({tag, "_latency"}, 64'(lat), 64'd17);
        checkValue({tag, "_busycycles"}, 64'(busyCnt), 64'd16);
        checkOutput(tag, m, q);
        prevProd = refProd(m, q);
        @(negedge clk);
        checkValue({tag, "_donepulse"}, {63'b0, done}, 64'd0);
        checkValue({tag, "_busyafter"}, {63'b0, busy}, 64'd0);
    endtask

    initial begin
        logic [15:0] bm [3];
        logic [15:0] bq [3];
        int          doneAt [3];
        int          nd;
        int          doneCnt;

        checks = 0;
        errors = 0;
        prevProd = 32'd0;
        rst_n = 1'b0;
        start = 1'b0;
        M = '0;
        Q = '0;

        @(negedge clk);
        checkValue("rst_prod", {32'b0, Prod}, 64'd0);
        checkValue("rst_busy", {63'b0, busy}, 64'd0);
        checkValue("rst_done", {63'b0, done}, 64'd0);
        checkValue("rst_flags", {61'b0, ZE, NE, OVF}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        runOp("basic", 16'd100, 16'd20, -1);
        runOp("negm", -16'sd100, 16'd20, -1);
        runOp("negq", 16'd100, -16'sd20, -1);
        runOp("negboth", -16'sd100, -16'sd20, -1);
        runOp("minmin", 16'h8000, 16'h8000, -1);
        runOp("ovf300", 16'd300, 16'd300, -1);
        runOp("minone", 16'h8000, 16'd1, -1);
        runOp("zero", 16'd0, 16'd12345, -1);
        runOp("minusone", 16'd12345, 16'hFFFF, -1);
        runOp("poke", 16'd1234, -16'sd77, 5);

        for (int i = 0; i < 12; i++) begin
            runOp("rand", 16'($urandom), 16'($urandom), -1);
        end

        // Back-to-back: start held high, operands refreshed after each done.
        bm[0] = 16'd321;   bq[0] = 16'd45;
        bm[1] = 16'h8000;  bq[1] = 16'h7FFF;
        bm[2] = -16'sd5;   bq[2] = 16'd9;
        M = bm[0];
        Q = bq[0];
        start = 1'b1;
        nd = 0;
        for (int t = 0; t < 80 && nd < 3; t++) begin
            @(negedge clk);
            if (done) begin
                doneAt[nd] = t;
                checkOutput("b2b", bm[nd], bq[nd]);
                prevProd = refProd(bm[nd], bq[nd]);
                nd++;
                if (nd < 3) begin
                    M = bm[nd];
                    Q = bq[nd];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checkValue("b2b_count", 64'(nd), 64'd3);
        if (nd == 3) begin
            checkValue("b2b_gap1", 64'(doneAt[1] - doneAt[0]), 64'd18);
            checkValue("b2b_gap2", 64'(doneAt[2] - doneAt[1]), 64'd18);
        end
        @(negedge clk);

        // Asynchronous abort in the middle of RUN.
        applyStimulus(16'd999, 16'd888);
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkValue("abort_prod", {32'b0, Prod}, 64'd0);
        checkValue("abort_busy", {63'b0, busy}, 64'd0);
        checkValue("abort_done", {63'b0, done}, 64'd0);
        checkValue("abort_flags", {61'b0, ZE, NE, OVF}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        prevProd = 32'd0;
        doneCnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            doneCnt += int'(done);
        end
        checkValue("abort_nodone", 64'(doneCnt), 64'd0);
        runOp("afterabort", 16'd7, -16'sd3, -1);
        checkValue("afterabort_val", {32'b0, Prod}, 64'hFFFF_FFEB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
